// File: rtl/calc_entry_ctrl.sv
// Keypad entry controller for a three-digit BCD calculator: collects A, an operator and B,
// then offers the operation to the ALU. Optional idle timeout when ENTRY_TIMEOUT_EN is defined.
module calc_entry_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 50_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    input  logic       enter_in,
    input  logic       alu_ready,
    output logic       alu_valid,
    output logic [9:0] op_a,
    output logic [9:0] op_b,
    output logic [1:0] op_code,
    output logic [9:0] entry_value,
    output logic [1:0] state_o,
    output logic       timeout_o
);

    // Handshake: alu_valid is held with op_a/op_b/op_code stable until a cycle where
    // alu_valid && alu_ready; that cycle is the transfer and alu_valid drops after it.
    typedef enum logic [1:0] {
        ENTER_A = 2'b00,
        ENTER_B = 2'b01,
        ISSUE   = 2'b10,
        DONE    = 2'b11
    } state_t;

    state_t     state;
    logic [3:0] a_d2, a_d1, a_d0;
    logic [3:0] b_d2, b_d1, b_d0;
    logic [1:0] a_cnt, b_cnt;

    logic       is_digit, is_op, is_bksp, is_enter;
    logic [1:0] key_op;
    logic       timeout_fire;

    function automatic logic [9:0] bcd_val(input logic [3:0] d2, input logic [3:0] d1,
                                           input logic [3:0] d0);
        return 10'(d2) * 10'd100 + 10'(d1) * 10'd10 + 10'(d0);
    endfunction

    // Enter takes priority over key_code; code F is the empty key.
    assign is_enter = key_valid && enter_in;
    assign is_digit = key_valid && !enter_in && (key_code <= 4'd9);
    assign is_op    = key_valid && !enter_in && (key_code >= 4'hA) && (key_code <= 4'hD);
    assign is_bksp  = key_valid && !enter_in && (key_code == 4'hE);
    assign key_op   = key_code[1:0] + 2'b10;  // A..D -> 00..11

    assign state_o  = state;

`ifdef ENTRY_TIMEOUT_EN
    logic [31:0] idle_cnt;
    logic        armed;
    logic        timeout_q;

    assign armed        = ((state == ENTER_A) && (a_cnt != 2'd0)) || (state == ENTER_B);
    assign timeout_fire = armed && !key_valid && (idle_cnt == 32'(TIMEOUT_CYCLES - 1));
    assign timeout_o    = timeout_q;

    always_ff @(posedge clk) begin
        if (rst || !armed || key_valid || timeout_fire) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_cnt + 32'd1;
        end
        if (rst) begin
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= timeout_fire;
        end
    end
`else
    assign timeout_fire = 1'b0;
    assign timeout_o    = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst || timeout_fire) begin
            state       <= ENTER_A;
            {a_d2, a_d1, a_d0} <= '0;
            {b_d2, b_d1, b_d0} <= '0;
            a_cnt       <= 2'd0;
            b_cnt       <= 2'd0;
            op_a        <= '0;
            op_b        <= '0;
            op_code     <= 2'b00;
            entry_value <= '0;
            alu_valid   <= 1'b0;
        end else begin
            case (state)
                ENTER_A: begin
                    if (is_digit && a_cnt != 2'd3) begin
                        {a_d2, a_d1, a_d0} <= {a_d1, a_d0, key_code};
                        a_cnt       <= a_cnt + 2'd1;
                        entry_value <= bcd_val(a_d1, a_d0, key_code);
                    end else if (is_bksp && a_cnt != 2'd0) begin
                        {a_d2, a_d1, a_d0} <= {4'd0, a_d2, a_d1};
                        a_cnt       <= a_cnt - 2'd1;
                        entry_value <= bcd_val(4'd0, a_d2, a_d1);
                    end else if (is_op && a_cnt != 2'd0) begin
                        op_a        <= bcd_val(a_d2, a_d1, a_d0);
                        op_code     <= key_op;
                        {b_d2, b_d1, b_d0} <= '0;
                        b_cnt       <= 2'd0;
                        entry_value <= '0;
                        state       <= ENTER_B;
                    end
                end
                ENTER_B: begin
                    if (is_digit && b_cnt != 2'd3) begin
                        {b_d2, b_d1, b_d0} <= {b_d1, b_d0, key_code};
                        b_cnt       <= b_cnt + 2'd1;
                        entry_value <= bcd_val(b_d1, b_d0, key_code);
                    end else if (is_bksp && b_cnt != 2'd0) begin
                        {b_d2, b_d1, b_d0} <= {4'd0, b_d2, b_d1};
                        b_cnt       <= b_cnt - 2'd1;
                        entry_value <= bcd_val(4'd0, b_d2, b_d1);
                    end else if (is_bksp) begin
                        // Backspace on an empty B undoes the operator; A is kept.
                        op_code     <= 2'b00;
                        entry_value <= bcd_val(a_d2, a_d1, a_d0);
                        state       <= ENTER_A;
                    end else if (is_op && b_cnt == 2'd0) begin
                        op_code <= key_op;
                    end else if (is_enter && b_cnt != 2'd0) begin
                        op_b        <= bcd_val(b_d2, b_d1, b_d0);
                        entry_value <= bcd_val(b_d2, b_d1, b_d0);
                        alu_valid   <= 1'b1;
                        state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (alu_valid && alu_ready) begin
                        alu_valid <= 1'b0;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (is_digit) begin
                        {a_d2, a_d1, a_d0} <= {4'd0, 4'd0, key_code};
                        a_cnt       <= 2'd1;
                        {b_d2, b_d1, b_d0} <= '0;
                        b_cnt       <= 2'd0;
                        op_a        <= '0;
                        op_b        <= '0;
                        entry_value <= bcd_val(4'd0, 4'd0, key_code);
                        state       <= ENTER_A;
                    end else if (is_bksp) begin
                        {a_d2, a_d1, a_d0} <= '0;
                        {b_d2, b_d1, b_d0} <= '0;
                        a_cnt       <= 2'd0;
                        b_cnt       <= 2'd0;
                        op_a        <= '0;
                        op_b        <= '0;
                        op_code     <= 2'b00;
                        entry_value <= '0;
                        state       <= ENTER_A;
                    end
                end
                default: state <= ENTER_A;
            endcase
        end
    end

endmodule

// File: tb/tb_calc_entry_ctrl.sv
// Directed bench for calc_entry_ctrl: inputs driven and outputs sampled on the falling edge.
module tb_calc_entry_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       key_valid = 1'b0;
    logic [3:0] key_code = 4'hF;
    logic       enter_in = 1'b0;
    logic       alu_ready = 1'b0;
    logic       alu_valid;
    logic [9:0] op_a, op_b, entry_value;
    logic [1:0] op_code, state_o;
    logic       timeout_o;

    int checks = 0;
    int errors = 0;

    calc_entry_ctrl #(.TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code),
        .enter_in(enter_in), .alu_ready(alu_ready), .alu_valid(alu_valid),
        .op_a(op_a), .op_b(op_b), .op_code(op_code), .entry_value(entry_value),
        .state_o(state_o), .timeout_o(timeout_o)
    );

    always #5 clk = ~clk;

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // One-cycle key strobe; returns on the falling edge after it was consumed.
    task automatic press(input logic [3:0] code, input logic ent);
        @(negedge clk);
        key_valid = 1'b1;
        key_code  = code;
        enter_in  = ent;
        @(negedge clk);
        key_valid = 1'b0;
        key_code  = 4'hF;
        enter_in  = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (state_o !== 2'b00) begin errors++; $display("FAIL reset_state got %0d exp 0", state_o); end
        checks++; if (alu_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", alu_valid); end
        checks++; if (op_a !== 10'd0) begin errors++; $display("FAIL reset_op_a got %0d exp 0", op_a); end
        checks++; if (op_b !== 10'd0) begin errors++; $display("FAIL reset_op_b got %0d exp 0", op_b); end
        checks++; if (op_code !== 2'b00) begin errors++; $display("FAIL reset_op_code got %0d exp 0", op_code); end
        checks++; if (entry_value !== 10'd0) begin errors++; $display("FAIL reset_entry got %0d exp 0", entry_value); end
        checks++; if (timeout_o !== 1'b0) begin errors++; $display("FAIL reset_timeout got %b exp 0", timeout_o); end
    endtask

    task automatic test_basic_add();
        do_reset();
        alu_ready = 1'b1;
        press(4'd1, 1'b0); press(4'd2, 1'b0); press(4'd3, 1'b0);
        checks++; if (entry_value !== 10'd123) begin errors++; $display("FAIL add_entry_a got %0d exp 123", entry_value); end
        press(4'hB, 1'b0);
        checks++; if (state_o !== 2'b01) begin errors++; $display("FAIL add_state_b got %0d exp 1", state_o); end
        checks++; if (op_a !== 10'd123) begin errors++; $display("FAIL add_op_a got %0d exp 123", op_a); end
        checks++; if (op_code !== 2'b01) begin errors++; $display("FAIL add_op_code got %0d exp 1", op_code); end
        checks++; if (entry_value !== 10'd0) begin errors++; $display("FAIL add_entry_b0 got %0d exp 0", entry_value); end
        press(4'd4, 1'b0); press(4'd5, 1'b0);
        checks++; if (entry_value !== 10'd45) begin errors++; $display("FAIL add_entry_b got %0d exp 45", entry_value); end
        press(4'hF, 1'b1);
        checks++; if (alu_valid !== 1'b1) begin errors++; $display("FAIL add_valid_hi got %b exp 1", alu_valid); end
        checks++; if (op_b !== 10'd45) begin errors++; $display("FAIL add_op_b got %0d exp 45", op_b); end
        @(negedge clk);
        checks++; if (alu_valid !== 1'b0) begin errors++; $display("FAIL add_valid_pulse got %b exp 0", alu_valid); end
        checks++; if (state_o !== 2'b11) begin errors++; $display("FAIL add_state_done got %0d exp 3", state_o); end
        checks++; if (entry_value !== 10'd45) begin errors++; $display("FAIL add_entry_done got %0d exp 45", entry_value); end
    endtask

    task automatic test_digit_limit();
        // Backspace from DONE clears everything.
        press(4'hE, 1'b0);
        checks++; if (state_o !== 2'b00) begin errors++; $display("FAIL limit_clear_state got %0d exp 0", state_o); end
        checks++; if (entry_value !== 10'd0) begin errors++; $display("FAIL limit_clear_entry got %0d exp 0", entry_value); end
        for (int i = 0; i < 4; i++) press(4'd9, 1'b0);
        checks++; if (entry_value !== 10'd999) begin errors++; $display("FAIL limit_999 got %0d exp 999", entry_value); end
        press(4'hE, 1'b0);
        checks++; if (entry_value !== 10'd99) begin errors++; $display("FAIL limit_bksp got %0d exp 99", entry_value); end
        press(4'd1, 1'b0);
        checks++; if (entry_value !== 10'd991) begin errors++; $display("FAIL limit_refill got %0d exp 991", entry_value); end
        press(4'hF, 1'b0);
        checks++; if (entry_value !== 10'd991) begin errors++; $display("FAIL limit_empty_key got %0d exp 991", entry_value); end
        press(4'hF, 1'b1);
        checks++; if (state_o !== 2'b00) begin errors++; $display("FAIL limit_enter_a got %0d exp 0", state_o); end
    endtask

    task automatic test_backspace_op();
        do_reset();
        press(4'd7, 1'b0); press(4'hC, 1'b0);
        checks++; if (op_code !== 2'b10) begin errors++; $display("FAIL bk_mul got %0d exp 2", op_code); end
        press(4'hE, 1'b0);
        checks++; if (state_o !== 2'b00) begin errors++; $display("FAIL bk_back_a got %0d exp 0", state_o); end
        checks++; if (entry_value !== 10'd7) begin errors++; $display("FAIL bk_a_kept got %0d exp 7", entry_value); end
        press(4'hE, 1'b0); press(4'hF, 1'b1);
        checks++; if (state_o !== 2'b00) begin errors++; $display("FAIL bk_state got %0d exp 0", state_o); end
        checks++; if (entry_value !== 10'd0) begin errors++; $display("FAIL bk_entry got %0d exp 0", entry_value); end
        checks++; if (op_code !== 2'b00) begin errors++; $display("FAIL bk_op_code got %0d exp 0", op_code); end
        checks++; if (alu_valid !== 1'b0) begin errors++; $display("FAIL bk_valid got %b exp 0", alu_valid); end
    endtask

    task automatic test_b_rules();
        do_reset();
        press(4'd8, 1'b0); press(4'hA, 1'b0); press(4'hF, 1'b1);
        checks++; if (state_o !== 2'b01) begin errors++; $display("FAIL brule_enter_empty got %0d exp 1", state_o); end
        press(4'hB, 1'b0);
        checks++; if (op_code !== 2'b01) begin errors++; $display("FAIL brule_replace got %0d exp 1", op_code); end
        press(4'd2, 1'b0); press(4'hC, 1'b0);
        checks++; if (op_code !== 2'b01) begin errors++; $display("FAIL brule_op_ignored got %0d exp 1", op_code); end
        checks++; if (entry_value !== 10'd2) begin errors++; $display("FAIL brule_entry got %0d exp 2", entry_value); end
    endtask

    task automatic test_stall();
        do_reset();
        alu_ready = 1'b0;
        press(4'd5, 1'b0); press(4'hA, 1'b0); press(4'hD, 1'b0); press(4'd3, 1'b0);
        press(4'hF, 1'b1);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (alu_valid !== 1'b1 || op_a !== 10'd5 || op_b !== 10'd3 || op_code !== 2'b11) begin
                errors++;
                $display("FAIL stall_hold cyc %0d valid %b a %0d b %0d op %0d exp 1 5 3 3", i, alu_valid, op_a, op_b, op_code);
            end
            @(negedge clk);
        end
        alu_ready = 1'b1;
        checks++; if (alu_valid !== 1'b1) begin errors++; $display("FAIL stall_fifth got %b exp 1", alu_valid); end
        @(negedge clk);
        alu_ready = 1'b0;
        checks++; if (alu_valid !== 1'b0) begin errors++; $display("FAIL stall_drop got %b exp 0", alu_valid); end
        checks++; if (state_o !== 2'b11) begin errors++; $display("FAIL stall_done got %0d exp 3", state_o); end
        press(4'd6, 1'b0);
        checks++; if (state_o !== 2'b00) begin errors++; $display("FAIL done_digit_state got %0d exp 0", state_o); end
        checks++; if (entry_value !== 10'd6) begin errors++; $display("FAIL done_digit_entry got %0d exp 6", entry_value); end
        checks++; if (op_a !== 10'd0) begin errors++; $display("FAIL done_digit_op_a got %0d exp 0", op_a); end
    endtask

    task automatic test_reset_issue();
        do_reset();
        alu_ready = 1'b0;
        press(4'd1, 1'b0); press(4'hB, 1'b0); press(4'd2, 1'b0); press(4'hF, 1'b1);
        checks++; if (alu_valid !== 1'b1) begin errors++; $display("FAIL rissue_pre got %b exp 1", alu_valid); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (alu_valid !== 1'b0) begin errors++; $display("FAIL rissue_valid got %b exp 0", alu_valid); end
        checks++; if (state_o !== 2'b00) begin errors++; $display("FAIL rissue_state got %0d exp 0", state_o); end
        checks++; if (op_a !== 10'd0) begin errors++; $display("FAIL rissue_op_a got %0d exp 0", op_a); end
    endtask

    task automatic test_timeout();
        do_reset();
        press(4'd4, 1'b0);
        for (int i = 0; i < 7; i++) @(negedge clk);
`ifdef ENTRY_TIMEOUT_EN
        checks++; if (timeout_o !== 1'b0 || entry_value !== 10'd4) begin errors++; $display("FAIL to_early tmo %b entry %0d exp 0 4", timeout_o, entry_value); end
        @(negedge clk);
        checks++; if (timeout_o !== 1'b1) begin errors++; $display("FAIL to_pulse got %b exp 1", timeout_o); end
        checks++; if (entry_value !== 10'd0 || state_o !== 2'b00) begin errors++; $display("FAIL to_clear entry %0d state %0d exp 0 0", entry_value, state_o); end
        @(negedge clk);
        checks++; if (timeout_o !== 1'b0) begin errors++; $display("FAIL to_one_cycle got %b exp 0", timeout_o); end
`else
        @(negedge clk);
        checks++; if (timeout_o !== 1'b0 || entry_value !== 10'd4) begin errors++; $display("FAIL to_disabled tmo %b entry %0d exp 0 4", timeout_o, entry_value); end
`endif
    endtask

    initial begin
        test_reset();
        test_basic_add();
        test_digit_limit();
        test_backspace_op();
        test_b_rules();
        test_stall();
        test_reset_issue();
        test_timeout();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
